// File: rtl/timer_pkg.sv
// Shared definitions for the timer subsystem (count-up and countdown blocks).
// State encoding, default parameters and a few small helpers live here.
package timer_pkg;

  localparam int DEFAULT_TICK_DIV = 100_000_000;
  localparam int DEFAULT_WIDTH    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_e;

  // Decoded control pulses for one cycle, after clear > start > pause priority.
  typedef struct packed {
    logic do_clear;
    logic do_launch;
    logic do_resume;
    logic do_pause;
  } timer_ctrl_t;

  // A run (re)begins only from a resting state; RUN and PAUSE never re-latch the target.
  function automatic logic can_launch(input timer_state_e st);
    return (st == IDLE) || (st == DONE);
  endfunction

  function automatic timer_ctrl_t decode_ctrl(input timer_state_e st,
                                              input logic start,
                                              input logic pause,
                                              input logic clear);
    timer_ctrl_t c;
    c           = '0;
    c.do_clear  = clear;
    c.do_launch = !clear && start && can_launch(st);
    c.do_resume = !clear && start && (st == PAUSE);
    // start outranks pause even in RUN, where start itself has no effect
    c.do_pause  = !clear && !start && pause && (st == RUN);
    return c;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// Holding enable low freezes the fractional count so pause/resume keeps it.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = enable && !clear && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (tick)   cnt_d = '0;
    else if (enable) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/countup_timer.sv
// Count-up stopwatch: counts whole seconds from 0 to a latched target, with
// pause/resume. FSM, elapsed/target and all outputs are registered here.
module countup_timer
  import timer_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int WIDTH    = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [WIDTH-1:0] set_time,
  output logic [WIDTH-1:0] elapsed,
  output logic             running,
  output logic             tick,
  output logic             done,
  output logic             done_pulse
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] elapsed_q, elapsed_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] elapsed_inc;
  logic             running_q, tick_q, done_q, done_pulse_q;
  logic             tick_d, done_pulse_d;
  logic             presc_en, presc_clr, presc_tick;
  timer_ctrl_t      ctrl;

  assign ctrl        = decode_ctrl(state_q, start, pause, clear);
  assign elapsed_inc = elapsed_q + ONE;

  // Prescaler only advances in RUN on cycles that do not leave RUN by pause/clear.
  assign presc_en  = (state_q == RUN) && !ctrl.do_clear && !ctrl.do_pause;
  assign presc_clr = ctrl.do_clear || ctrl.do_launch;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .clk    (clk),
    .rst    (rst),
    .enable (presc_en),
    .clear  (presc_clr),
    .tick   (presc_tick)
  );

  always_comb begin
    state_d      = state_q;
    elapsed_d    = elapsed_q;
    target_d     = target_q;
    tick_d       = 1'b0;
    done_pulse_d = 1'b0;
    if (ctrl.do_clear) begin
      state_d   = IDLE;
      elapsed_d = '0;
    end else if (ctrl.do_launch) begin
      target_d  = set_time;
      elapsed_d = '0;
      if (set_time == '0) begin
        state_d      = DONE;
        done_pulse_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (ctrl.do_resume) begin
      state_d = RUN;
    end else if (ctrl.do_pause) begin
      state_d = PAUSE;
    end else if ((state_q == RUN) && presc_tick) begin
      elapsed_d = elapsed_inc;
      tick_d    = 1'b1;
      if (elapsed_inc == target_q) begin
        state_d      = DONE;
        done_pulse_d = 1'b1;
      end
    end
  end

  // Outputs are derived from next state so they line up with the new elapsed value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      elapsed_q    <= '0;
      target_q     <= '0;
      running_q    <= 1'b0;
      tick_q       <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      elapsed_q    <= elapsed_d;
      target_q     <= target_d;
      running_q    <= (state_d == RUN);
      tick_q       <= tick_d;
      done_q       <= (state_d == DONE);
      done_pulse_q <= done_pulse_d;
    end
  end

  assign elapsed    = elapsed_q;
  assign running    = running_q;
  assign tick       = tick_q;
  assign done       = done_q;
  assign done_pulse = done_pulse_q;

endmodule
